// File: rtl/wb_uart.sv
// Wishbone classic slave UART (8N1) for the J1 data bus.
// TX FIFO, single-byte RX holding register, programmable divisor.
module wb_uart #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] adr_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic        txd_o,
  input  logic        rxd_i
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  logic        ack_q;
  logic [15:0] dat_q;
  logic [15:0] div_q;
  logic        tx_ovf_q, rx_ovr_q, rx_ferr_q;
  logic        rx_valid_q;
  logic [7:0]  rx_byte_q;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;

  logic [1:0]  tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d;

  logic        s1_q, s2_q, sp_q;
  logic [2:0]  rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_load, rx_ferr_set;

  logic        acc;
  logic [1:0]  sel;
  logic        wr_data, rd_data, wr_stat, wr_div;
  logic [15:0] eff_div, bit_ld, half_ld;
  logic        empty, full, pop, push_ok, tx_busy;
  logic [15:0] rd_mux;
  logic        unused_ok;

  assign unused_ok = ^{adr_i[15:3], adr_i[0]};

  assign acc     = cyc_i & stb_i & ~ack_q;
  assign sel     = adr_i[2:1];
  assign wr_data = acc & we_i & (sel == 2'd0);
  assign rd_data = acc & ~we_i & (sel == 2'd0);
  assign wr_stat = acc & we_i & (sel == 2'd1);
  assign wr_div  = acc & we_i & (sel == 2'd2);

  // Divisors below 2 would make the half-bit wait degenerate.
  assign eff_div = (div_q < 16'd2) ? 16'd2 : div_q;
  assign bit_ld  = eff_div - 16'd1;
  assign half_ld = (eff_div >> 1) - 16'd1;

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop     = (tx_st_q == TX_IDLE) & ~empty;
  assign push_ok = wr_data & (~full | pop);
  assign tx_busy = (tx_st_q != TX_IDLE);

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign txd_o = txd_q;

  // Register read multiplexer.
  always_comb begin
    rd_mux = 16'h0;
    case (sel)
      2'd0: rd_mux = {8'h0, rx_byte_q};
      2'd1: rd_mux = {10'h0, tx_busy, rx_ferr_q, rx_ovr_q,
                      tx_ovf_q, rx_valid_q, full};
      2'd2: rd_mux = div_q;
      default: rd_mux = 16'h0;
    endcase
  end

  // Bus handshake, read data and the divisor register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 16'h0;
      div_q <= DIV_RESET;
    end else begin
      ack_q <= acc;
      dat_q <= (acc & ~we_i) ? rd_mux : 16'h0;
      if (wr_div) div_q <= dat_i;
    end
  end

  // FIFO storage; contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wp_q[AW-1:0]] <= dat_i[7:0];
  end

  // FIFO pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop)     rp_q <= rp_q + 1'b1;
    end
  end

  // TX frame sequencer; bit length re-read at every bit boundary.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    case (tx_st_q)
      TX_IDLE: if (!empty) begin
        tx_st_d  = TX_START;
        tx_sh_d  = mem_q[rp_q[AW-1:0]];
        txd_d    = 1'b0;
        tx_cnt_d = bit_ld;
      end
      TX_START: if (tx_cnt_q == 16'd0) begin
        tx_st_d  = TX_DATA;
        txd_d    = tx_sh_q[0];
        tx_cnt_d = bit_ld;
        tx_bit_d = 3'd0;
      end else tx_cnt_d = tx_cnt_q - 16'd1;
      TX_DATA: if (tx_cnt_q == 16'd0) begin
        tx_cnt_d = bit_ld;
        if (tx_bit_q == 3'd7) begin
          tx_st_d = TX_STOP;
          txd_d   = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          txd_d    = tx_sh_q[1];
        end
      end else tx_cnt_d = tx_cnt_q - 16'd1;
      TX_STOP: if (tx_cnt_q == 16'd0) tx_st_d = TX_IDLE;
               else tx_cnt_d = tx_cnt_q - 16'd1;
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // TX state registers; line idles high out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= 16'h0;
      tx_bit_q <= 3'd0;
      tx_sh_q  <= 8'h0;
      txd_q    <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      txd_q    <= txd_d;
    end
  end

  // RX sequencer: start qualify at half bit, then sample each bit centre.
  always_comb begin
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_load     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (sp_q && !s2_q) begin
        rx_st_d  = RX_START;
        rx_cnt_d = half_ld;
      end
      RX_START: if (rx_cnt_q == 16'd0) begin
        if (!s2_q) begin
          rx_st_d  = RX_DATA;
          rx_cnt_d = bit_ld;
          rx_bit_d = 3'd0;
        end else rx_st_d = RX_IDLE;
      end else rx_cnt_d = rx_cnt_q - 16'd1;
      RX_DATA: if (rx_cnt_q == 16'd0) begin
        rx_sh_d  = {s2_q, rx_sh_q[7:1]};
        rx_cnt_d = bit_ld;
        if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q - 16'd1;
      RX_STOP: if (rx_cnt_q == 16'd0) begin
        if (s2_q) begin
          rx_load = 1'b1;
          rx_st_d = RX_IDLE;
        end else begin
          rx_ferr_set = 1'b1;
          rx_st_d     = RX_BREAK;
        end
      end else rx_cnt_d = rx_cnt_q - 16'd1;
      RX_BREAK: if (s2_q) rx_st_d = RX_IDLE;
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // RX synchroniser and state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      sp_q     <= 1'b1;
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= 16'h0;
      rx_bit_q <= 3'd0;
      rx_sh_q  <= 8'h0;
    end else begin
      s1_q     <= rxd_i;
      s2_q     <= s1_q;
      sp_q     <= s2_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
    end
  end

  // Holding register and sticky flags; a new byte beats a same-cycle read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_byte_q  <= 8'h0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      if (rx_load) rx_byte_q <= rx_sh_q;
      if (rx_load) rx_valid_q <= 1'b1;
      else if (rd_data) rx_valid_q <= 1'b0;
      if (rx_load && rx_valid_q && !rd_data) rx_ovr_q <= 1'b1;
      else if (wr_stat && dat_i[2]) rx_ovr_q <= 1'b0;
      if (rx_ferr_set) rx_ferr_q <= 1'b1;
      else if (wr_stat && dat_i[3]) rx_ferr_q <= 1'b0;
      if (wr_data && full && !pop) tx_ovf_q <= 1'b1;
      else if (wr_stat && dat_i[1]) tx_ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_uart.sv
// Scoreboard bench for wb_uart: bus reads and TX frames
// are queued at stimulus time and checked by monitors.
module tb_wb_uart;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adr = '0;
  logic [15:0] dat_w = '0;
  logic [15:0] dat_r;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic        ack, txd, rxd;
  logic        rxd_drv = 1'b1;
  logic        loop = 1'b0;

  int vectors = 0;
  int errors = 0;
  int tx_div = 16;
  bit tx_ignore = 1'b0;

  logic [15:0] rd_q[$];
  string       rd_nm[$];
  logic [7:0]  tx_q[$];

  always #5 clk = ~clk;

  always_comb rxd = loop ? txd : rxd_drv;

  wb_uart #(.FIFO_DEPTH(8), .DIV_RESET(16'd16)) dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_w),
    .dat_o(dat_r), .we_i(we), .cyc_i(cyc), .stb_i(stb),
    .ack_o(ack), .txd_o(txd), .rxd_i(rxd)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Read-data monitor.
  always @(negedge clk) begin
    if (!rst && ack && !we) begin
      if (rd_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL rd_unexpected: got %h expected none", dat_r);
      end else chk(rd_nm.pop_front(), dat_r, rd_q.pop_front());
    end
  end

  // TX frame monitor.
  initial begin
    logic [7:0] b;
    logic       st, sb;
    int         d;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        d = tx_div;
        repeat (d / 2) @(negedge clk);
        st = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          b[i] = txd;
        end
        repeat (d) @(negedge clk);
        sb = txd;
        if (!tx_ignore) begin
          vectors++;
          if (tx_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got %h expected none", b);
          end else begin
            e = tx_q.pop_front();
            if (st !== 1'b0 || sb !== 1'b1 || b !== e) begin
              errors++;
              $display("FAIL tx_frame: got %h start %b stop %b expected %h",
                       b, st, sb, e);
            end
          end
        end
      end
    end
  end

  task automatic bus(input bit w, input logic [1:0] a,
                     input logic [15:0] d, input logic [15:0] e,
                     input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (ack) @(negedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = {13'h0, a, 1'b0}; dat_w = d;
    if (!w) begin
      rd_q.push_back(e);
      rd_nm.push_back(nm);
    end
    do begin @(posedge clk); n++; #1; end while (!ack && n < 8);
    cyc = 1'b0; stb = 1'b0;
    chk({nm, "_ack_lat"}, 16'(n), 16'd1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d,
                    input string nm);
    bus(1'b1, a, d, 16'h0, nm);
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] e,
                    input string nm);
    bus(1'b0, a, 16'h0, e, nm);
  endtask

  // Held-strobe write burst to DATA: one transfer every 2 clocks.
  task automatic burst(input logic [7:0] first, input int cnt);
    int n;
    @(negedge clk);
    while (ack) @(negedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0;
    for (int i = 0; i < cnt; i++) begin
      n = 0;
      dat_w = 16'(first) + 16'(i);
      do begin @(posedge clk); n++; #1; end while (!ack && n < 8);
      chk("burst_ack_lat", 16'(n), (i == 0) ? 16'd1 : 16'd2);
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wait_tx();
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) begin
      vectors++; errors++;
      $display("FAIL tx_drain_timeout: got %0d frames left expected 0",
               tx_q.size());
    end
    repeat (20) @(negedge clk);
  endtask

  // Drive one 8N1 frame at 4 clocks per bit on rxd.
  task automatic send_rx(input logic [7:0] b, input logic stopb);
    @(posedge clk); #1 rxd_drv = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd_drv = b[i];
      repeat (4) @(posedge clk);
    end
    #1 rxd_drv = stopb;
    repeat (4) @(posedge clk);
    if (!stopb) begin
      #1 rxd_drv = 1'b0;
      repeat (4) @(posedge clk);
    end
    #1 rxd_drv = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("txd_in_reset", {15'h0, txd}, 16'h1);
    chk("ack_in_reset", {15'h0, ack}, 16'h0);
    rst = 1'b0;

    rd(2'd1, 16'h0000, "stat_reset");
    rd(2'd2, 16'h0010, "div_reset");
    rd(2'd3, 16'h0000, "reg3_read");
    chk("txd_idle", {15'h0, txd}, 16'h1);

    wr(2'd2, 16'd4, "div_wr");
    tx_div = 4;
    tx_q.push_back(8'h55);
    wr(2'd0, 16'h0055, "data_55");
    rd(2'd1, 16'h0020, "stat_busy");
    wait_tx();
    rd(2'd1, 16'h0000, "stat_idle");
    rd(2'd2, 16'h0004, "div_rd");

    for (int i = 0; i < 9; i++) tx_q.push_back(8'(i));
    burst(8'h00, 19);
    rd(2'd1, 16'h0025, "stat_full_ovf");
    wr(2'd1, 16'h0002, "w1c_ovf");
    wait_tx();
    rd(2'd1, 16'h0000, "stat_ovf_clr");

    loop = 1'b1;
    tx_q.push_back(8'hA5);
    wr(2'd0, 16'h00A5, "data_a5");
    wait_tx();
    rd(2'd1, 16'h0002, "stat_rxv");
    rd(2'd0, 16'h00A5, "rx_a5");
    rd(2'd1, 16'h0000, "stat_rx_rd");

    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    wr(2'd0, 16'h0011, "data_11");
    wr(2'd0, 16'h0022, "data_22");
    wait_tx();
    rd(2'd1, 16'h000A, "stat_ovr");
    rd(2'd0, 16'h0022, "rx_22");
    rd(2'd1, 16'h0008, "stat_ovr_only");
    wr(2'd1, 16'h0004, "w1c_ovr");
    rd(2'd1, 16'h0000, "stat_ovr_clr");
    loop = 1'b0;
    repeat (10) @(negedge clk);

    send_rx(8'h5A, 1'b1);
    rd(2'd1, 16'h0002, "stat_rx5a");
    send_rx(8'h3C, 1'b0);
    rd(2'd1, 16'h0012, "stat_ferr");
    rd(2'd0, 16'h005A, "rx_5a_kept");
    rd(2'd1, 16'h0010, "stat_ferr_only");
    wr(2'd1, 16'h0008, "w1c_ferr");
    rd(2'd1, 16'h0000, "stat_ferr_clr");

    @(posedge clk); #1 rxd_drv = 1'b0;
    @(posedge clk); #1 rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    rd(2'd1, 16'h0000, "stat_glitch");
    rd(2'd0, 16'h005A, "rx_stale");
    rd(2'd1, 16'h0000, "stat_stale");

    tx_ignore = 1'b1;
    wr(2'd0, 16'h0000, "data_00");
    repeat (10) @(negedge clk);
    chk("txd_midframe", {15'h0, txd}, 16'h0);
    #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0004;
    @(posedge clk); #1;
    chk("ack_before_rst", {15'h0, ack}, 16'h1);
    rst = 1'b1;
    #1;
    chk("ack_at_rst", {15'h0, ack}, 16'h0);
    chk("txd_at_rst", {15'h0, txd}, 16'h1);
    cyc = 1'b0; stb = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd(2'd1, 16'h0000, "stat_after_rst");
    rd(2'd2, 16'h0010, "div_after_rst");
    chk("txd_after_rst", {15'h0, txd}, 16'h1);

    repeat (60) @(negedge clk);
    chk("rd_q_empty", 16'(rd_q.size()), 16'h0);
    chk("tx_q_empty", 16'(tx_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
